// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 6-digit 7-segment display: digit prescaler, inter-digit blanking
// and frame-granular arbitration between two requesters for the displayed 24-bit word.
module seg_scan_ctrl #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16,
  parameter int HOLD_FRM  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [23:0] data0,
  input  logic        req1,
  input  logic [23:0] data1,
  output logic [23:0] disp_num,
  output logic [2:0]  scanning,
  output logic        blank,
  output logic        gnt0,
  output logic        gnt1,
  output logic        owner,
  output logic        frame_end
);

  localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FC_W = (HOLD_FRM > 0) ? $clog2(HOLD_FRM + 1) : 1;
  localparam logic [PC_W-1:0] PC_MAX  = PC_W'(DIV - 1);
  localparam logic [PC_W-1:0] BLANK_V = PC_W'(BLANK_CYC);
  localparam logic [FC_W-1:0] FC_HOLD = FC_W'(HOLD_FRM);

  logic [PC_W-1:0] r_pc;
  logic [FC_W-1:0] r_fc;
  logic [2:0]      r_scan;
  logic [23:0]     r_disp;
  logic            r_blank;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_owner;
  logic            r_frame_end;

  logic [PC_W-1:0] w_pc_nxt;
  logic            w_tick;
  logic            w_own_req;
  logic            w_oth_req;
  logic            w_latch;
  logic            w_sel;
  logic            w_switch;

  assign w_tick   = (r_pc == PC_MAX);
  assign w_pc_nxt = w_tick ? '0 : r_pc + 1'b1;

  // Prescaler, digit index and blanking; blank is derived from the next pc value so it
  // rises on the same cycle the digit index changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_scan      <= 3'd0;
      r_blank     <= 1'b1;
      r_frame_end <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_blank     <= (w_pc_nxt < BLANK_V);
      r_frame_end <= w_tick && (r_scan == 3'd5);
      if (w_tick)
        r_scan <= (r_scan == 3'd5) ? 3'd0 : r_scan + 3'd1;
    end
  end

  assign w_own_req = r_owner ? req1 : req0;
  assign w_oth_req = r_owner ? req0 : req1;

  // Ownership decision, only taken on the frame boundary so the word never changes mid-frame.
  always_comb begin
    w_latch  = 1'b0;
    w_sel    = r_owner;
    w_switch = 1'b0;
    if (r_frame_end) begin
      if (w_own_req && (r_fc < FC_HOLD)) begin
        w_latch = 1'b1;
      end else if (w_oth_req) begin
        w_latch  = 1'b1;
        w_sel    = ~r_owner;
        w_switch = 1'b1;
      end else if (w_own_req) begin
        w_latch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fc    <= '0;
      r_owner <= 1'b0;
      r_disp  <= 24'd0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else begin
      r_gnt0 <= w_latch && !w_sel;
      r_gnt1 <= w_latch && w_sel;
      if (r_frame_end) begin
        r_owner <= w_sel;
        if (w_switch)
          r_fc <= '0;
        else if (r_fc != FC_HOLD)
          r_fc <= r_fc + 1'b1;
      end
      if (w_latch)
        r_disp <= w_sel ? data1 : data0;
    end
  end

  assign disp_num  = r_disp;
  assign scanning  = r_scan;
  assign blank     = r_blank;
  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign owner     = r_owner;
  assign frame_end = r_frame_end;

endmodule
